// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: bundles the three requester ports, the memory command
// port and the tag/credit feedback shared by mem_req_arbiter.
//   slave  modport : the arbiter (consumes requests, drives the memory command)
//   master modport : the requester/memory side (drives requests and tags)
// Handshake: a requester holds *_req_valid (with stable addr/data) until it sees
// its *_accepted pulse; a command is accepted in the cycle it is presented
// when current_req_tag != 0, and the requester samples that tag in that cycle.
interface mem_req_arbiter_if #(
  parameter int MAX_OUTSTANDING = 15
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic          ic_req_valid;
  logic [31:0]   ic_req_addr;
  logic          dl_req_valid;
  logic [31:0]   dl_req_addr;
  logic          wb_req_valid;
  logic [31:0]   wb_req_addr;
  logic [63:0]   wb_req_data;
  logic [3:0]    current_req_tag;
  logic [3:0]    mem_data_tag;
  logic [1:0]    mem_command;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_store_data;
  logic          ic_accepted;
  logic          dl_accepted;
  logic          wb_accepted;
  logic [OW-1:0] outstanding;

  modport slave (
    input  ic_req_valid, ic_req_addr, dl_req_valid, dl_req_addr,
           wb_req_valid, wb_req_addr, wb_req_data, current_req_tag, mem_data_tag,
    output mem_command, mem_addr, mem_store_data,
           ic_accepted, dl_accepted, wb_accepted, outstanding
  );

  modport master (
    output ic_req_valid, ic_req_addr, dl_req_valid, dl_req_addr,
           wb_req_valid, wb_req_addr, wb_req_data, current_req_tag, mem_data_tag,
    input  mem_command, mem_addr, mem_store_data,
           ic_accepted, dl_accepted, wb_accepted, outstanding
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single memory command port between icache fills
// (ic), dcache load misses (dl) and dcache writebacks (wb).
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : mem_req_arbiter_if.slave (requests, command, tags, outstanding)
//   lock_locked  : debug, lock FSM is in LOCKED
//   lock_owner   : debug, requester held by the lock (0 ic, 1 dl, 2 wb)
// Selection is combinational (zero-cycle grant). A rejected command (tag 0)
// locks the arbiter onto that requester until it is accepted or withdraws.
// Loads are credit-limited by the count of in-flight load tags.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = `NUM_MEM_TAGS,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_req_arbiter_if.slave     bus,
  output logic                 lock_locked,
  output logic [1:0]           lock_owner
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {IDLE, LOCKED} lock_state_t;
  typedef enum logic [1:0] {REQ_IC = 2'd0, REQ_DL = 2'd1, REQ_WB = 2'd2, REQ_NONE = 2'd3} req_t;

  lock_state_t   lock_q, lock_d;
  req_t          owner_q, owner_d;
  req_t          sel;
  logic [OW-1:0] out_q, out_d;
  logic [SW-1:0] ic_cnt_q, ic_cnt_d, dl_cnt_q, dl_cnt_d;

  logic credit_ok, ic_elig, dl_elig, wb_elig;
  logic owner_valid, owner_elig, accept;
  logic ic_starved, dl_starved;

  assign credit_ok  = out_q < OW'(MAX_OUTSTANDING);
  assign ic_elig    = bus.ic_req_valid && credit_ok;
  assign dl_elig    = bus.dl_req_valid && credit_ok;
  assign wb_elig    = bus.wb_req_valid;
  assign ic_starved = ic_cnt_q == SW'(STARVE_LIMIT);
  assign dl_starved = dl_cnt_q == SW'(STARVE_LIMIT);

  always_comb begin
    owner_valid = 1'b0;
    owner_elig  = 1'b0;
    case (owner_q)
      REQ_IC:  begin owner_valid = bus.ic_req_valid; owner_elig = ic_elig; end
      REQ_DL:  begin owner_valid = bus.dl_req_valid; owner_elig = dl_elig; end
      REQ_WB:  begin owner_valid = bus.wb_req_valid; owner_elig = wb_elig; end
      default: begin owner_valid = 1'b0;             owner_elig = 1'b0;    end
    endcase
  end

  // Requester selection. A locked owner that is still valid but out of credit
  // blocks everyone else so its rejected command is not overtaken.
  always_comb begin
    sel = REQ_NONE;
    if (lock_q == LOCKED && owner_valid) begin
      sel = owner_elig ? owner_q : REQ_NONE;
    end else if (dl_starved && dl_elig) begin
      sel = REQ_DL;
    end else if (ic_starved && ic_elig) begin
      sel = REQ_IC;
    end else if (wb_elig) begin
      sel = REQ_WB;
    end else if (dl_elig) begin
      sel = REQ_DL;
    end else if (ic_elig) begin
      sel = REQ_IC;
    end
    if (reset) sel = REQ_NONE;
  end

  always_comb begin
    bus.mem_command    = CMD_NONE;
    bus.mem_addr       = 32'd0;
    bus.mem_store_data = 64'd0;
    case (sel)
      REQ_WB: begin
        bus.mem_command    = CMD_STORE;
        bus.mem_addr       = bus.wb_req_addr;
        bus.mem_store_data = bus.wb_req_data;
      end
      REQ_DL: begin
        bus.mem_command = CMD_LOAD;
        bus.mem_addr    = bus.dl_req_addr;
      end
      REQ_IC: begin
        bus.mem_command = CMD_LOAD;
        bus.mem_addr    = bus.ic_req_addr;
      end
      default: ;
    endcase
  end

  assign accept          = (sel != REQ_NONE) && (bus.current_req_tag != 4'd0);
  assign bus.ic_accepted = accept && sel == REQ_IC;
  assign bus.dl_accepted = accept && sel == REQ_DL;
  assign bus.wb_accepted = accept && sel == REQ_WB;

  // Lock FSM next state. Release is evaluated first so that a rejection by a
  // different requester in the release cycle re-locks onto that requester.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (lock_q == LOCKED && (!owner_valid || (accept && sel == owner_q))) lock_d = IDLE;
    if (lock_d == IDLE && sel != REQ_NONE && bus.current_req_tag == 4'd0) begin
      lock_d  = LOCKED;
      owner_d = sel;
    end
  end

  // Starvation counters: count waiting cycles, saturate, clear on accept/withdraw.
  always_comb begin
    ic_cnt_d = ic_cnt_q;
    dl_cnt_d = dl_cnt_q;
    if (!bus.ic_req_valid || bus.ic_accepted) ic_cnt_d = '0;
    else if (!ic_starved)                     ic_cnt_d = ic_cnt_q + SW'(1);
    if (!bus.dl_req_valid || bus.dl_accepted) dl_cnt_d = '0;
    else if (!dl_starved)                     dl_cnt_d = dl_cnt_q + SW'(1);
  end

  // In-flight loads: a response at count 0 (e.g. a pre-reset tag) is dropped.
  always_comb begin
    logic inc, dec;
    inc   = accept && bus.mem_command == CMD_LOAD;
    dec   = bus.mem_data_tag != 4'd0 && out_q != '0;
    out_d = out_q;
    if (inc && !dec)      out_d = out_q + OW'(1);
    else if (dec && !inc) out_d = out_q - OW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q   <= IDLE;
      owner_q  <= REQ_NONE;
      out_q    <= '0;
      ic_cnt_q <= '0;
      dl_cnt_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      out_q    <= out_d;
      ic_cnt_q <= ic_cnt_d;
      dl_cnt_q <= dl_cnt_d;
    end
  end

  assign bus.outstanding = out_q;
  assign lock_locked     = lock_q == LOCKED;
  assign lock_owner      = owner_q;
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single processor-to-memory command port between three requesters: icache line fills, dcache load misses, and dcache dirty-line writebacks. It sits between the icache/dcache subsystems and the memory model, replacing their direct `mem_req_addr`/`mem_req_accepted` hookups. It sequences requests with fixed priority plus anti-starvation aging, holds a rejected grant until it is accepted, and enforces a credit limit on outstanding loads using the memory's returned tags.

## Interface
- `MAX_OUTSTANDING`, default `` `NUM_MEM_TAGS `` (15): maximum in-flight load transactions (tags 1..15).
- `STARVE_LIMIT`, default 8: consecutive waiting cycles after which icache or dload is promoted.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `ic_req_valid` input 1: icache fill request.
- `ic_req_addr` input 32: icache line address, 8-byte aligned.
- `dl_req_valid` input 1: dcache load-miss request.
- `dl_req_addr` input 32: load line address.
- `wb_req_valid` input 1: dcache writeback request.
- `wb_req_addr` input 32: writeback line address.
- `wb_req_data` input 64: writeback line data.
- `current_req_tag` input 4: memory's tag for this cycle's command; 0 = rejected.
- `mem_data_tag` input 4: tag of returning load data; 0 = none.
- `mem_command` output 2: 0 NONE, 1 LOAD, 2 STORE.
- `mem_addr` output 32: address of issued command.
- `mem_store_data` output 64: `wb_req_data` when STORE, else 0.
- `ic_accepted`, `dl_accepted`, `wb_accepted` output 1 each: one-hot pulse, requester's command accepted this cycle.
- `outstanding` output `$clog2(MAX_OUTSTANDING+1)`: current in-flight load count.

## Operation
- Eligibility: wb is eligible when `wb_req_valid`. ic and dl are eligible when their valid is high and `outstanding < MAX_OUTSTANDING`. Stores never consume credit.
- Selection order:
  1. Locked requester, if lock valid and it is eligible.
  2. A starved requester, dl before ic.
  3. wb.
  4. dl.
  5. ic.
- If nothing is eligible: `mem_command`=NONE, `mem_addr`=0.
- Command: wb→STORE, dl/ic→LOAD; `mem_addr` is the selected requester's address.
- Acceptance: `<sel>_accepted` = command≠NONE && `current_req_tag`≠0. The requester consumes the tag by sampling `current_req_tag` the same cycle.
- Lock state (IDLE/LOCKED, with `lock_id` ∈ {ic, dl, wb}):
  - IDLE→LOCKED(sel) when command≠NONE and `current_req_tag`==0.
  - LOCKED→IDLE on acceptance of the locked requester, or when the locked requester's valid is low.
  - While LOCKED with the locked requester valid but credit-blocked: command NONE, no other requester issues, lock held.
- Starvation counters (ic, dl), each saturating at `STARVE_LIMIT`:
  - +1 per cycle valid && !accepted.
  - Cleared on accept or when valid is low.
  - Starved means count == `STARVE_LIMIT`.
- Outstanding counter:
  - +1 on accepted LOAD.
  - −1 when `mem_data_tag`≠0 and count>0.
  - Both in the same cycle → unchanged.
  - Response while count==0 → ignored; never underflows.
  - Never exceeds `MAX_OUTSTANDING`.

## Timing
- Issue and accept path is combinational from requests, `current_req_tag` and registered state. Zero-cycle grant.
- Lock, starvation and outstanding registers update on the rising edge; their effects are visible the next cycle.
- Reset asserted at any time, including mid-lock or with loads in flight:
  - `outstanding`=0, lock IDLE, starvation counters 0, immediately (async).
  - While reset is high: `mem_command`=NONE, `mem_addr`=0, `mem_store_data`=0, all `*_accepted`=0.
  - Responses for pre-reset tags arriving after reset are ignored by the count-0 rule.
- At most one command and one accept pulse per cycle.

## Test plan
- All three valid, `current_req_tag`=3 every cycle:
  - Cycle 0 STORE wb addr (`wb_accepted`=1).
  - Drop wb; next cycle LOAD dl, `outstanding` 0→1.
  - Drop dl; next cycle LOAD ic.
- dl valid, `current_req_tag`=0 for 3 cycles, wb raised during cycle 1:
  - dl stays selected (LOCKED) for all 3 cycles.
  - Tag=5 in cycle 3 gives `dl_accepted`=1.
  - wb issues in cycle 4.
- ic valid continuously while wb and dl stay valid and are accepted each cycle (ic always denied):
  - After 8 denied cycles ic is starved.
  - Cycle 9 issues LOAD ic over wb.
- Issue 15 accepted loads:
  - `outstanding`=15; ic/dl get NONE while wb STOREs still issue.
  - `mem_data_tag`=7 → `outstanding`=14, next load issues.
  - Load accept and `mem_data_tag`≠0 in the same cycle → count unchanged.
- `mem_data_tag`=2 with `outstanding`=0 → stays 0.
- Assert reset mid-lock with `outstanding`=4:
  - Outputs go idle immediately; count 0, lock IDLE.
  - After release, priority restarts from wb.
